// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the
// processor data port (requester 0) and the loader/debug port (requester 1).
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              lock0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wd0,
    output logic              gnt0,
    output logic              ack0,
    output logic [DATA_W-1:0] rd0,
    input  logic              req1,
    input  logic              lock1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd1,
    output logic              gnt1,
    output logic              ack1,
    output logic [DATA_W-1:0] rd1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam int CNT_W = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state, state_n;
    logic             last_owner, last_owner_n;
    logic [CNT_W-1:0] hold_cnt, hold_cnt_n;

    // Reset also kills any in-flight write, since mem_we derives from state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            hold_cnt   <= '0;
        end else begin
            state      <= state_n;
            last_owner <= last_owner_n;
            hold_cnt   <= hold_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        last_owner_n = last_owner;
        hold_cnt_n   = hold_cnt;
        case (state)
            IDLE: begin
                if (req0 && (!req1 || last_owner)) begin
                    state_n      = OWN0;
                    last_owner_n = 1'b0;
                    hold_cnt_n   = ONE_CNT;
                end else if (req1) begin
                    state_n      = OWN1;
                    last_owner_n = 1'b1;
                    hold_cnt_n   = ONE_CNT;
                end
            end
            OWN0: begin
                if (req0) begin
                    // Lock only caps the hold when the other side is waiting.
                    if (lock0 && (hold_cnt < MAX_CNT)) begin
                        hold_cnt_n = hold_cnt + ONE_CNT;
                    end else if (req1) begin
                        state_n      = OWN1;
                        last_owner_n = 1'b1;
                        hold_cnt_n   = ONE_CNT;
                    end else begin
                        hold_cnt_n = ONE_CNT;
                    end
                end else if (req1) begin
                    state_n      = OWN1;
                    last_owner_n = 1'b1;
                    hold_cnt_n   = ONE_CNT;
                end else begin
                    state_n = IDLE;
                end
            end
            OWN1: begin
                if (req1) begin
                    if (lock1 && (hold_cnt < MAX_CNT)) begin
                        hold_cnt_n = hold_cnt + ONE_CNT;
                    end else if (req0) begin
                        state_n      = OWN0;
                        last_owner_n = 1'b0;
                        hold_cnt_n   = ONE_CNT;
                    end else begin
                        hold_cnt_n = ONE_CNT;
                    end
                end else if (req0) begin
                    state_n      = OWN0;
                    last_owner_n = 1'b0;
                    hold_cnt_n   = ONE_CNT;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);
    assign ack0 = gnt0 & req0;
    assign ack1 = gnt1 & req1;

    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        rd0      = '0;
        rd1      = '0;
        if (ack0) begin
            mem_we   = we0;
            mem_addr = addr0;
            mem_wd   = wd0;
            rd0      = mem_rd;
        end else if (ack1) begin
            mem_we   = we1;
            mem_addr = addr1;
            mem_wd   = wd1;
            rd1      = mem_rd;
        end
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-requester arbiter sharing the single-port data memory (async read, write on posedge clk) between requester 0 (processor data port) and requester 1 (loader/DMA/debug port). Sits between the requesters and data_mem and drives its we/address/wd inputs. Uses round-robin fairness with an optional bounded lock for back-to-back atomic sequences.

Parameters:
ADDR_W, 32, address width of requester and memory address ports
DATA_W, 32, data width
MAX_HOLD, 4, max consecutive transfers one owner may keep while its lock is high and the other requester is waiting (>=1)

Ports:
clk  input  1  system clock, all state changes on posedge
reset  input  1  asynchronous, active-low reset (reset=0 clears state immediately)
req0  input  1  requester 0 transfer request; held with we0/addr0/wd0 stable until ack0
lock0  input  1  requester 0 wants to keep the grant after the current transfer
we0  input  1  1=write, 0=read
addr0  input  ADDR_W  byte address, word aligned
wd0  input  DATA_W  write data
gnt0  output  1  requester 0 owns memory this cycle
ack0  output  1  requester 0 transfer completes at the next posedge
rd0  output  DATA_W  read data, valid while ack0=1, else 0
req1, lock1, we1, addr1, wd1, gnt1, ack1, rd1  same as above for requester 1
mem_we  output  1  to data_mem we
mem_addr  output  ADDR_W  to data_mem address
mem_wd  output  DATA_W  to data_mem wd
mem_rd  input  DATA_W  from data_mem rd

Behaviour:
- State: fsm {IDLE, OWN0, OWN1}; last_owner (1 bit); hold_cnt (enough bits to count to MAX_HOLD).
- Reset (reset=0, async): fsm=IDLE, last_owner=1 (requester 0 wins the first tie), hold_cnt=0. All outputs 0 in IDLE.
- gnt0=(fsm==OWN0), gnt1=(fsm==OWN1); combinational from state.
- ackN=gntN & reqN (combinational). In OWNn with reqn=1: mem_we=wen, mem_addr=addrn, mem_wd=wdn, rdn=mem_rd. The write commits at the posedge ending the ack cycle.
- No owner, or owner with req low: mem_we=0, mem_addr=0, mem_wd=0, rd0=rd1=0.
- IDLE transitions: no req -> IDLE. Only reqN -> OWNN. Both -> the requester != last_owner.
- Entering OWNN: last_owner<=N, hold_cnt<=1.
- OWNN, at the posedge where ackN=1:
  - if lockN=1 and hold_cnt<MAX_HOLD: stay, hold_cnt+1.
  - else if the other requester's req=1: switch to OWN(other), hold_cnt<=1.
  - else if reqN=1 (next transfer, unlocked): stay, hold_cnt<=1.
  - else IDLE.
- Lock only bounds the hold while the other requester is waiting. If the other req=0 and lockN=1 at hold_cnt==MAX_HOLD, stay and reset hold_cnt to 1.
- OWNN with reqN=0 (request withdrawn, no ack): no memory write. Next state: OWN(other) if the other req=1, else IDLE.
- Latency: req in IDLE at cycle n -> gnt/ack at cycle n+1. The handoff between requesters has zero bubble cycles. Sustained contention without lock alternates 0,1,0,1 with one transfer per cycle.
- Asserting reset mid-transfer forces mem_we=0 immediately, so no partial write occurs.

Test Plan:
- Reset then single write: hold reset=0, check all outputs 0. Release, then req0=1, we0=1, addr0=0x10, wd0=0xDEADBEEF -> next cycle gnt0=ack0=1, mem_we=1, mem_addr=0x10; afterwards data_mem word 4 = 0xDEADBEEF. Drop req0 -> IDLE, outputs 0.
- Read by requester 1: preload word 8 = 0x12345678; req1=1, we1=0, addr1=0x20 -> ack1=1, rd1=0x12345678, mem_we=0, rd0=0.
- Contention: req0 and req1 raised in the same cycle and held with different addresses -> ack sequence 0,1,0,1 on consecutive cycles, no idle cycle between owners.
- Lock bound (MAX_HOLD=4): req0=lock0=1 and req1=1 held -> exactly 4 consecutive ack0, then ack1. With req1=0, lock0 holds OWN0 indefinitely.
- Withdrawn request: req0 one-cycle pulse in IDLE -> next cycle gnt0=1, ack0=0, mem_we=0, then IDLE. No memory word changes.
- Async reset mid-write: reset=0 between edges while in OWN0 with we0=1 -> gnt0, ack0, mem_we drop to 0 before the next posedge, target word unchanged, and after release the first tie goes to requester 0.
